// File: rtl/seq_flag_alu_if.sv
// Request/response bundle for seq_flag_alu: operation request in, result and flag-register write port out.
interface seq_flag_alu_if;
    logic        start;
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic [2:0]  flag_out;
    logic [2:0]  flag_wen;

    modport master (
        output start, op, a, b,
        input  busy, done, result, flag_out, flag_wen
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, flag_out, flag_wen
    );
endinterface

// File: rtl/seq_flag_alu.sv
// Sequential ALU with saturating add/sub, bit-serial shifts and {N,V,Z} flag-register write port.
// Optional nibble-wise saturating add (op 111) enabled by macro SEQ_FLAG_ALU_PADDSB_EN.
module seq_flag_alu (
    input  logic          clk,
    input  logic          rst_n,
    seq_flag_alu_if.slave bus
);
    localparam logic [2:0] OP_ADD    = 3'b000;
    localparam logic [2:0] OP_SUB    = 3'b001;
    localparam logic [2:0] OP_XOR    = 3'b010;
    localparam logic [2:0] OP_SLL    = 3'b100;
    localparam logic [2:0] OP_SRA    = 3'b101;
    localparam logic [2:0] OP_ROR    = 3'b110;
    localparam logic [2:0] OP_PADDSB = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] shreg_q, shreg_d;
    logic [2:0]  op_q, op_d;
    logic [15:0] result_q, result_d;
    logic [2:0]  flag_out_q, flag_out_d;
    logic [2:0]  flag_wen_q, flag_wen_d;
    logic        done_q, done_d;
    logic        busy_q;

    logic        fin_s;
    logic [15:0] res_s;
    logic        v_s;
    logic [2:0]  wen_s;
    logic [19:0] imm_s;

    // Returns {overflow, saturated 16-bit sum}; subtraction uses the two's-complement of y.
    function automatic logic [16:0] sat_addsub(input logic [15:0] x, input logic [15:0] y, input logic sub);
        logic [15:0] yy;
        logic [16:0] s;
        logic [15:0] r;
        logic        ovf;
        yy  = sub ? ~y : y;
        s   = {x[15], x} + {yy[15], yy} + {16'h0000, sub};
        ovf = s[16] ^ s[15];
        if (ovf) begin
            r = s[16] ? 16'h8000 : 16'h7FFF;
        end else begin
            r = s[15:0];
        end
        return {ovf, r};
    endfunction

`ifdef SEQ_FLAG_ALU_PADDSB_EN
    function automatic logic [15:0] paddsb(input logic [15:0] x, input logic [15:0] y);
        logic [15:0] r;
        logic [4:0]  n;
        r = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            n = {x[4*i+3], x[4*i +: 4]} + {y[4*i+3], y[4*i +: 4]};
            if (n[4] ^ n[3]) begin
                r[4*i +: 4] = n[4] ? 4'h8 : 4'h7;
            end else begin
                r[4*i +: 4] = n[3:0];
            end
        end
        return r;
    endfunction
`endif

    function automatic logic [15:0] shift_step(input logic [2:0] op, input logic [15:0] v);
        case (op)
            OP_SLL:  return {v[14:0], 1'b0};
            OP_SRA:  return {v[15], v[15:1]};
            OP_ROR:  return {v[0], v[15:1]};
            default: return v;
        endcase
    endfunction

    // Single-cycle ops, and shifts by zero; returns {flag_wen, V, result}.
    function automatic logic [19:0] imm_op(input logic [2:0] op, input logic [15:0] x, input logic [15:0] y);
        logic [16:0] as;
        as = sat_addsub(x, y, op == OP_SUB);
        case (op)
            OP_ADD, OP_SUB:         return {3'b111, as};
            OP_XOR:                 return {3'b001, 1'b0, x ^ y};
            OP_SLL, OP_SRA, OP_ROR: return {3'b001, 1'b0, x};
`ifdef SEQ_FLAG_ALU_PADDSB_EN
            OP_PADDSB:              return {3'b000, 1'b0, paddsb(x, y)};
`endif
            default:                return {3'b000, 1'b0, 16'h0000};
        endcase
    endfunction

    // Next-state, datapath and output computation.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shreg_d    = shreg_q;
        op_d       = op_q;
        result_d   = result_q;
        flag_out_d = 3'b000;
        flag_wen_d = 3'b000;
        done_d     = 1'b0;
        fin_s      = 1'b0;
        res_s      = 16'h0000;
        v_s        = 1'b0;
        wen_s      = 3'b000;
        imm_s      = 20'h00000;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    op_d = bus.op;
                    if ((bus.op == OP_SLL || bus.op == OP_SRA || bus.op == OP_ROR) && bus.b[3:0] != 4'd0) begin
                        state_d = ST_SHIFT;
                        cnt_d   = bus.b[3:0];
                        shreg_d = bus.a;
                    end else begin
                        imm_s   = imm_op(bus.op, bus.a, bus.b);
                        state_d = ST_DONE;
                        fin_s   = 1'b1;
                        wen_s   = imm_s[19:17];
                        v_s     = imm_s[16];
                        res_s   = imm_s[15:0];
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                res_s   = shift_step(op_q, shreg_q);
                shreg_d = res_s;
                cnt_d   = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = ST_DONE;
                    fin_s   = 1'b1;
                    wen_s   = 3'b001;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Flags are only presented, and only writable, in the completion cycle.
        if (fin_s) begin
            done_d     = 1'b1;
            result_d   = res_s;
            flag_out_d = {res_s[15], v_s, res_s == 16'h0000};
            flag_wen_d = wen_s;
        end else begin
            done_d     = 1'b0;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            shreg_q    <= 16'h0000;
            op_q       <= 3'b000;
            result_q   <= 16'h0000;
            flag_out_q <= 3'b000;
            flag_wen_q <= 3'b000;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shreg_q    <= shreg_d;
            op_q       <= op_d;
            result_q   <= result_d;
            flag_out_q <= flag_out_d;
            flag_wen_q <= flag_wen_d;
            done_q     <= done_d;
            busy_q     <= (state_d != ST_IDLE);
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.result   = result_q;
    assign bus.flag_out = flag_out_q;
    assign bus.flag_wen = flag_wen_q;
endmodule
